// File: rtl/instr_fetch_pkg.sv
// Shared fetch/decode definitions: opcode field values, fetch FSM states,
// next-PC selector and the default bubble instruction.
package instr_fetch_pkg;

  localparam logic [1:0] OP_ALU    = 2'b00;
  localparam logic [1:0] OP_LOAD   = 2'b01;
  localparam logic [1:0] OP_STORE  = 2'b10;
  localparam logic [1:0] OP_BRANCH = 2'b11;

  // Branch opcode with zero offset: the decoder performs no register or memory write.
  localparam logic [7:0] BUBBLE_INSTR_DEFAULT = {OP_BRANCH, 6'd0};

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } fetchState_e;

  typedef enum logic [1:0] {
    PC_HOLD   = 2'd0,
    PC_INC    = 2'd1,
    PC_BRANCH = 2'd2
  } pcSel_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and memory.
interface instr_fetch_if #(
  parameter int PC_WIDTH = 8
) ();

  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_ack;
  logic [7:0]          imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/instr_fetch_pc_next.sv
// Combinational next-PC selection: hold, sequential increment, or taken-branch target.
module pc_next
  import instr_fetch_pkg::*;
#(
  parameter int PC_WIDTH = 8
) (
  input  pcSel_e              sel,
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [PC_WIDTH-1:0] instrPc,
  input  logic [7:0]          offset,
  output logic [PC_WIDTH-1:0] nextPc
);

  logic signed [PC_WIDTH-1:0] offsetExt;

  // Sign-extend the 8-bit offset; all sums wrap modulo 2**PC_WIDTH.
  assign offsetExt = PC_WIDTH'(signed'(offset));

  always_comb begin
    nextPc = pc;
    case (sel)
      PC_INC:    nextPc = pc + PC_WIDTH'(1);
      PC_BRANCH: nextPc = instrPc + PC_WIDTH'(1) + offsetExt;
      default:   nextPc = pc;
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: issues one instruction-memory request at a time, captures the word
// into the IR, and hands it to the decoder until the downstream stage accepts it.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int                  PC_WIDTH     = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC     = '0,
  parameter logic [7:0]          BUBBLE_INSTR = BUBBLE_INSTR_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  instr_fetch_if.master       imem,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [7:0]          branch_offset,
  output logic [7:0]          instr,
  output logic [1:0]          op,
  output logic                instr_valid,
  output logic [PC_WIDTH-1:0] instr_pc
);

  fetchState_e         state;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pcNxt;
  pcSel_e              pcSel;

  always_comb begin
    pcSel = PC_HOLD;
    if (state == S_FETCH && imem.imem_ack)
      pcSel = PC_INC;
    else if (state == S_HOLD && !stall && branch_taken)
      pcSel = PC_BRANCH;
  end

  pc_next #(
    .PC_WIDTH (PC_WIDTH)
  ) uPcNext (
    .sel     (pcSel),
    .pc      (pc),
    .instrPc (instr_pc),
    .offset  (branch_offset),
    .nextPc  (pcNxt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      instr       <= BUBBLE_INSTR;
      instr_valid <= 1'b0;
      instr_pc    <= '0;
    end else begin
      pc <= pcNxt;
      case (state)
        S_FETCH: begin
          if (imem.imem_ack) begin
            instr       <= imem.imem_rdata;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            state       <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            instr       <= BUBBLE_INSTR;
            instr_valid <= 1'b0;
            state       <= S_FETCH;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  // Gating with the reset net lets the first request appear in the very first
  // cycle after release while staying low throughout reset.
  assign imem.imem_req  = (state == S_FETCH) && reset;
  assign imem.imem_addr = pc;
  assign op             = instr[7:6];

endmodule
